// File: rtl/wts_key_pkg.sv
// Shared command codes, default register addresses and channel count for the
// 5-channel key controller.
package wts_key_pkg;

    typedef enum logic [1:0] {
        WTS_KEY_NONE    = 2'b00,
        WTS_KEY_ON      = 2'b01,
        WTS_KEY_RELEASE = 2'b10,
        WTS_KEY_OFF     = 2'b11
    } key_cmd_e;

    localparam int          NUM_CH                 = 5;
    localparam logic [7:0]  WTS_REG_ADDR_KEY       = 8'h40;
    localparam logic [7:0]  WTS_REG_ADDR_GATE_BASE = 8'h48;

endpackage

// File: rtl/wts_key_slot.sv
// Per-channel pending command, keyed status and one-hot command outputs.
// Gate timer (auto-release after gate_len ticks) only when WTS_KEY_GATE_EN is defined.
module wts_key_slot
    import wts_key_pkg::*;
(
    input  logic       clk,
    input  logic       nreset,
    input  logic       wr_hit,
    input  key_cmd_e   wr_cmd,
    input  logic       deliver,
    input  logic       tick,
    input  logic       gate_wr,
    input  logic [7:0] gate_data,
    output key_cmd_e   pending,
    output logic       status,
    output logic       key_on,
    output logic       key_release,
    output logic       key_off
);

    key_cmd_e pend_nxt;
    logic     dlv;
    logic     expire;

    assign dlv = deliver && (pending != WTS_KEY_NONE);

`ifdef WTS_KEY_GATE_EN
    logic [7:0] gate_len;
    logic [7:0] gate_cnt;

    assign expire = tick && (gate_cnt == 8'd1) && (pending == WTS_KEY_NONE) && status;

    // A fresh ON write disarms the timer even if an old ON is delivered on the same edge.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            gate_len <= '0;
            gate_cnt <= '0;
        end else begin
            if (gate_wr) gate_len <= gate_data;
            if (wr_hit && (wr_cmd == WTS_KEY_ON)) begin
                gate_cnt <= '0;
            end else if (dlv && (pending == WTS_KEY_ON)) begin
                if (gate_len != 8'd0) gate_cnt <= gate_len;
            end else if (dlv) begin
                gate_cnt <= '0;
            end else if (tick && (gate_cnt != 8'd0)) begin
                gate_cnt <= gate_cnt - 8'd1;
            end
        end
    end
`else
    logic unused_gate;
    assign unused_gate = ^{tick, gate_wr, gate_data};
    assign expire      = 1'b0;
`endif

    // CPU write beats both delivery-clear and gate expiry.
    always_comb begin
        pend_nxt = pending;
        if (wr_hit)      pend_nxt = wr_cmd;
        else if (dlv)    pend_nxt = WTS_KEY_NONE;
        else if (expire) pend_nxt = WTS_KEY_RELEASE;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pending     <= WTS_KEY_NONE;
            status      <= 1'b0;
            key_on      <= 1'b0;
            key_release <= 1'b0;
            key_off     <= 1'b0;
        end else begin
            pending     <= pend_nxt;
            key_on      <= (pend_nxt == WTS_KEY_ON);
            key_release <= (pend_nxt == WTS_KEY_RELEASE);
            key_off     <= (pend_nxt == WTS_KEY_OFF);
            if (dlv) status <= (pending == WTS_KEY_ON);
        end
    end

endmodule

// File: rtl/wts_key_controller_5ch.sv
// CPU key command decoder for the 5-channel TDM envelope generator: one
// wts_key_slot per channel. Optional gate timers via WTS_KEY_GATE_EN.
module wts_key_controller_5ch
    import wts_key_pkg::*;
#(
    parameter logic [7:0] REG_ADDR_KEY       = WTS_REG_ADDR_KEY,
    parameter logic [7:0] REG_ADDR_GATE_BASE = WTS_REG_ADDR_GATE_BASE
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic [2:0] active,
    input  logic       bus_write,
    input  logic [7:0] bus_address,
    input  logic [7:0] bus_wdata,
    input  logic       tick,
    output logic       ch_a_key_on,
    output logic       ch_b_key_on,
    output logic       ch_c_key_on,
    output logic       ch_d_key_on,
    output logic       ch_e_key_on,
    output logic       ch_a_key_release,
    output logic       ch_b_key_release,
    output logic       ch_c_key_release,
    output logic       ch_d_key_release,
    output logic       ch_e_key_release,
    output logic       ch_a_key_off,
    output logic       ch_b_key_off,
    output logic       ch_c_key_off,
    output logic       ch_d_key_off,
    output logic       ch_e_key_off,
    output logic [4:0] key_status,
    output logic [4:0] key_pending
);

    logic                 key_hit;
    key_cmd_e             wr_cmd;
    logic                 unused_wdata;
    key_cmd_e [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0]    k_on, k_rel, k_off;

    assign key_hit      = bus_write && (bus_address == REG_ADDR_KEY);
    assign wr_cmd       = key_cmd_e'(bus_wdata[6:5]);
    assign unused_wdata = bus_wdata[7];

    for (genvar n = 0; n < NUM_CH; n++) begin : g_slot
        wts_key_slot u_slot (
            .clk        (clk),
            .nreset     (nreset),
            .wr_hit     (key_hit && bus_wdata[n]),
            .wr_cmd     (wr_cmd),
            .deliver    (active == 3'(n)),
            .tick       (tick),
            .gate_wr    (bus_write && (bus_address == REG_ADDR_GATE_BASE + 8'(n))),
            .gate_data  (bus_wdata),
            .pending    (pend[n]),
            .status     (key_status[n]),
            .key_on     (k_on[n]),
            .key_release(k_rel[n]),
            .key_off    (k_off[n])
        );
        assign key_pending[n] = (pend[n] != WTS_KEY_NONE);
    end

    assign {ch_e_key_on, ch_d_key_on, ch_c_key_on, ch_b_key_on, ch_a_key_on} = k_on;
    assign {ch_e_key_release, ch_d_key_release, ch_c_key_release,
            ch_b_key_release, ch_a_key_release} = k_rel;
    assign {ch_e_key_off, ch_d_key_off, ch_c_key_off, ch_b_key_off, ch_a_key_off} = k_off;

endmodule

// File: tb/tb_wts_key_controller_5ch.sv
// Self-checking bench for wts_key_controller_5ch: directed scenarios plus a
// random run against a per-channel command/status model.
module tb_wts_key_controller_5ch;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [2:0] active = 3'd5;
    logic       bus_write = 1'b0;
    logic [7:0] bus_address = 8'h00;
    logic [7:0] bus_wdata = 8'h00;
    logic       tick = 1'b0;
    logic       ch_a_key_on, ch_b_key_on, ch_c_key_on, ch_d_key_on, ch_e_key_on;
    logic       ch_a_key_release, ch_b_key_release, ch_c_key_release, ch_d_key_release, ch_e_key_release;
    logic       ch_a_key_off, ch_b_key_off, ch_c_key_off, ch_d_key_off, ch_e_key_off;
    logic [4:0] key_status, key_pending;

    int n_checks = 0;
    int n_errors = 0;

    // model: command 0 none, 1 on, 2 release, 3 off
    int m_pend[5];
    bit m_stat[5];
    int m_glen[5];
    int m_gcnt[5];

    wts_key_controller_5ch dut (
        .clk(clk), .nreset(nreset), .active(active), .bus_write(bus_write),
        .bus_address(bus_address), .bus_wdata(bus_wdata), .tick(tick),
        .ch_a_key_on(ch_a_key_on), .ch_b_key_on(ch_b_key_on), .ch_c_key_on(ch_c_key_on),
        .ch_d_key_on(ch_d_key_on), .ch_e_key_on(ch_e_key_on),
        .ch_a_key_release(ch_a_key_release), .ch_b_key_release(ch_b_key_release),
        .ch_c_key_release(ch_c_key_release), .ch_d_key_release(ch_d_key_release),
        .ch_e_key_release(ch_e_key_release),
        .ch_a_key_off(ch_a_key_off), .ch_b_key_off(ch_b_key_off), .ch_c_key_off(ch_c_key_off),
        .ch_d_key_off(ch_d_key_off), .ch_e_key_off(ch_e_key_off),
        .key_status(key_status), .key_pending(key_pending)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] k_on();
        return {ch_e_key_on, ch_d_key_on, ch_c_key_on, ch_b_key_on, ch_a_key_on};
    endfunction
    function automatic logic [4:0] k_rel();
        return {ch_e_key_release, ch_d_key_release, ch_c_key_release, ch_b_key_release, ch_a_key_release};
    endfunction
    function automatic logic [4:0] k_off();
        return {ch_e_key_off, ch_d_key_off, ch_c_key_off, ch_b_key_off, ch_a_key_off};
    endfunction
    function automatic logic [24:0] act_vec();
        return {k_on(), k_rel(), k_off(), key_status, key_pending};
    endfunction
    function automatic logic [24:0] exp_vec();
        logic [4:0] on, rel, off, st, pd;
        for (int c = 0; c < 5; c++) begin
            on[c]  = (m_pend[c] == 1);
            rel[c] = (m_pend[c] == 2);
            off[c] = (m_pend[c] == 3);
            st[c]  = m_stat[c];
            pd[c]  = (m_pend[c] != 0);
        end
        return {on, rel, off, st, pd};
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < 5; c++) begin
            m_pend[c] = 0; m_stat[c] = 0; m_glen[c] = 0; m_gcnt[c] = 0;
        end
    endfunction

    // Applies the rules for one rising edge using the inputs present before it.
    function automatic void model_edge();
        int cmd;
        cmd = int'(bus_wdata[6:5]);
        for (int c = 0; c < 5; c++) begin
            bit hit, del, exp_g;
            int old_p;
            old_p = m_pend[c];
            hit   = bus_write && (bus_address == 8'h40) && bus_wdata[c];
            del   = (int'(active) == c) && (old_p != 0);
            exp_g = 1'b0;
`ifdef WTS_KEY_GATE_EN
            exp_g = tick && (m_gcnt[c] == 1) && (old_p == 0) && m_stat[c];
            if (hit && cmd == 1) m_gcnt[c] = 0;
            else if (del && old_p == 1) begin
                if (m_glen[c] != 0) m_gcnt[c] = m_glen[c];
            end
            else if (del) m_gcnt[c] = 0;
            else if (tick && m_gcnt[c] != 0) m_gcnt[c] = m_gcnt[c] - 1;
            if (bus_write && (int'(bus_address) == 8'h48 + c)) m_glen[c] = int'(bus_wdata);
`endif
            if (del) m_stat[c] = (old_p == 1);
            if (hit)        m_pend[c] = cmd;
            else if (del)   m_pend[c] = 0;
            else if (exp_g) m_pend[c] = 2;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic key_write(input logic [7:0] d, input logic [2:0] act);
        bus_write = 1'b1; bus_address = 8'h40; bus_wdata = d; active = act;
        step();
        bus_write = 1'b0;
    endtask

    task automatic test_reset();
        logic [24:0] a;
        model_reset();
        nreset = 1'b0;
        repeat (2) @(posedge clk);
        #2 nreset = 1'b1;
        #1;
        n_checks++;
        a = act_vec();
        if (a !== 25'd0) begin
            n_errors++; $display("FAIL reset_init: got %h want 0", a);
        end
        key_write(8'h21, 3'd5);
        n_checks++;
        if (ch_a_key_on !== 1'b1) begin
            n_errors++; $display("FAIL reset_pre_on: got %b want 1", ch_a_key_on);
        end
        active = 3'd3;
        #2 nreset = 1'b0;
        #1;
        model_reset();
        n_checks++;
        a = act_vec();
        if (a !== 25'd0) begin
            n_errors++; $display("FAIL reset_async: got %h want 0", a);
        end
        @(negedge clk);
        nreset = 1'b1;
        active = 3'd5;
    endtask

    task automatic test_basic();
        logic [24:0] e, a;
        key_write(8'h23, 3'd5);
        for (int s = 0; s <= 5; s++) begin
            active = 3'(s);
            step();
            e = exp_vec(); a = act_vec();
            n_checks++;
            if (a !== e) begin
                n_errors++; $display("FAIL basic_slot%0d: got %h want %h", s, a, e);
            end
        end
        n_checks++;
        if (key_status !== 5'b00011) begin
            n_errors++; $display("FAIL basic_status: got %b want 00011", key_status);
        end
    endtask

    task automatic test_overwrite();
        bit saw_on = 1'b0;
        key_write(8'h24, 3'd5);
        key_write(8'h64, 3'd0);
        for (int s = 0; s < 6; s++) begin
            if (ch_c_key_on) saw_on = 1'b1;
            active = 3'(s);
            step();
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_errors++; $display("FAIL overwrite_slot%0d: got %h want %h", s, act_vec(), exp_vec());
            end
        end
        n_checks++;
        if (saw_on || key_status[2] !== 1'b0) begin
            n_errors++; $display("FAIL overwrite_c: got on_seen=%0b status=%b want 0 0", saw_on, key_status[2]);
        end
    endtask

    task automatic test_collision();
        key_write(8'h48, 3'd5);
        n_checks++;
        if (ch_d_key_release !== 1'b1) begin
            n_errors++; $display("FAIL coll_rel_pending: got %b want 1", ch_d_key_release);
        end
        key_write(8'h28, 3'd3);
        n_checks++;
        if ({ch_d_key_on, ch_d_key_release, key_status[3]} !== 3'b100) begin
            n_errors++; $display("FAIL coll_edge: got on/rel/st=%b%b%b want 100",
                                 ch_d_key_on, ch_d_key_release, key_status[3]);
        end
        active = 3'd3;
        step();
        n_checks++;
        if ({ch_d_key_on, key_status[3]} !== 2'b01 || act_vec() !== exp_vec()) begin
            n_errors++; $display("FAIL coll_deliver: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_idle();
        key_write(8'h3F, 3'd5);
        active = 3'd5;
        for (int i = 0; i < 20; i++) begin
            active = 3'(5 + (i % 3));
            step();
            n_checks++;
            if (k_on() !== 5'h1F || key_pending !== 5'h1F) begin
                n_errors++; $display("FAIL idle_hold%0d: got on=%h pend=%h want 1f 1f", i, k_on(), key_pending);
            end
        end
        for (int s = 0; s < 5; s++) begin
            active = 3'(s);
            step();
        end
        n_checks++;
        if (key_pending !== 5'h00 || key_status !== 5'h1F) begin
            n_errors++; $display("FAIL idle_drain: got pend=%h st=%h want 00 1f", key_pending, key_status);
        end
    endtask

`ifdef WTS_KEY_GATE_EN
    task automatic test_gate();
        bus_write = 1'b1; bus_address = 8'h4C; bus_wdata = 8'd3; active = 3'd5;
        step();
        key_write(8'h30, 3'd5);
        active = 3'd4;
        step();
        active = 3'd5;
        tick = 1'b1;
        for (int t = 0; t < 3; t++) begin
            n_checks++;
            if (ch_e_key_release !== 1'b0) begin
                n_errors++; $display("FAIL gate_early%0d: got %b want 0", t, ch_e_key_release);
            end
            step();
        end
        tick = 1'b0;
        n_checks++;
        if (ch_e_key_release !== 1'b1 || act_vec() !== exp_vec()) begin
            n_errors++; $display("FAIL gate_expire: got %h want %h", act_vec(), exp_vec());
        end
        active = 3'd4;
        step();
        n_checks++;
        if (ch_e_key_release !== 1'b0 || key_status[4] !== 1'b0) begin
            n_errors++; $display("FAIL gate_deliver: got rel=%b st=%b want 0 0", ch_e_key_release, key_status[4]);
        end
        bus_write = 1'b1; bus_address = 8'h4C; bus_wdata = 8'd0; active = 3'd5;
        step();
        bus_write = 1'b0;
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int sel;
            active    = 3'($urandom_range(0, 7));
            tick      = ($urandom_range(0, 3) == 0);
            bus_write = ($urandom_range(0, 2) == 0);
            sel       = int'($urandom_range(0, 3));
            bus_address = (sel < 2) ? 8'h40 :
                          (sel == 2) ? 8'(8'h48 + $urandom_range(0, 4)) : 8'($urandom);
            bus_wdata = (sel == 2) ? 8'($urandom_range(0, 4)) : 8'($urandom);
            step();
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_errors++; $display("FAIL random%0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
        bus_write = 1'b0; tick = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overwrite();
        test_collision();
        test_idle();
`ifdef WTS_KEY_GATE_EN
        test_gate();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
